// File: rtl/halftone_cell_accum.sv
`default_nettype none
// ============================================================================
// halftone_cell_accum: sums 8-bit luminance over CELL_W x CELL_H halftone cells
// in raster order. Optional macro HALFTONE_INVERT_EN emits (max sum - sum).
// Rev 1.0
// ============================================================================
module halftone_cell_accum #(
  parameter int CELL_W         = 4,
  parameter int CELL_H         = 2,
  parameter int CELLS_PER_LINE = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              px_valid,
  input  logic                              px_sof,
  input  logic [7:0]                        px_lum,
  output logic [10:0]                       g,
  output logic                              g_valid,
  output logic [$clog2(CELLS_PER_LINE)-1:0] cell_x,
  output logic [7:0]                        cell_y
);

  localparam int          PCW     = $clog2(CELL_W);
  localparam int          RW      = $clog2(CELL_H);
  localparam int          CXW     = $clog2(CELLS_PER_LINE);
  localparam logic [10:0] MAX_SUM = 11'(CELL_W * CELL_H * 255);

  logic [PCW-1:0] px_col_q,   px_col_d,   px_col_eff;
  logic [CXW-1:0] cell_col_q, cell_col_d, cell_col_eff;
  logic [RW-1:0]  cell_row_q, cell_row_d, cell_row_eff;
  logic [7:0]     cell_y_q,   cell_y_d,   cell_y_eff;
  logic [10:0]    h_acc_q,    h_acc_d;
  logic [10:0]    lbuf_q [CELLS_PER_LINE];

  logic [10:0]    g_q, g_d;
  logic           g_valid_q, g_valid_d;
  logic [CXW-1:0] cell_x_q, cell_x_d;
  logic [7:0]     cell_y_out_q, cell_y_out_d;

  logic [10:0]    h_sum, lbuf_rd, row_sum;
  logic           last_px, last_row, last_cell, lbuf_we;

  always_comb begin
    // A start-of-frame pixel is evaluated as if all counters were zero.
    px_col_eff   = px_sof ? '0 : px_col_q;
    cell_col_eff = px_sof ? '0 : cell_col_q;
    cell_row_eff = px_sof ? '0 : cell_row_q;
    cell_y_eff   = px_sof ? '0 : cell_y_q;

    last_px   = (px_col_eff == PCW'(CELL_W - 1));
    last_row  = (cell_row_eff == RW'(CELL_H - 1));
    last_cell = (cell_col_eff == CXW'(CELLS_PER_LINE - 1));

    h_sum   = (px_col_eff == '0) ? {3'b000, px_lum} : h_acc_q + {3'b000, px_lum};
    lbuf_rd = lbuf_q[cell_col_eff];
    row_sum = (cell_row_eff == '0) ? h_sum : lbuf_rd + h_sum;

    lbuf_we   = px_valid && last_px && !last_row;
    g_valid_d = px_valid && last_px && last_row;

    px_col_d     = px_col_q;
    cell_col_d   = cell_col_q;
    cell_row_d   = cell_row_q;
    cell_y_d     = cell_y_q;
    h_acc_d      = h_acc_q;
    g_d          = g_q;
    cell_x_d     = cell_x_q;
    cell_y_out_d = cell_y_out_q;

    if (px_valid) begin
      h_acc_d    = h_sum;
      px_col_d   = px_col_eff;
      cell_col_d = cell_col_eff;
      cell_row_d = cell_row_eff;
      cell_y_d   = cell_y_eff;
      if (last_px) begin
        px_col_d = '0;
        if (last_cell) begin
          cell_col_d = '0;
          if (last_row) begin
            cell_row_d = '0;
            cell_y_d   = cell_y_eff + 8'd1;
          end else begin
            cell_row_d = cell_row_eff + 1'b1;
          end
        end else begin
          cell_col_d = cell_col_eff + 1'b1;
        end
      end else begin
        px_col_d = px_col_eff + 1'b1;
      end
    end

    if (g_valid_d) begin
`ifdef HALFTONE_INVERT_EN
      g_d = MAX_SUM - row_sum;
`else
      g_d = row_sum;
`endif
      cell_x_d     = cell_col_eff;
      cell_y_out_d = cell_y_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_col_q     <= '0;
      cell_col_q   <= '0;
      cell_row_q   <= '0;
      cell_y_q     <= '0;
      h_acc_q      <= '0;
      g_q          <= '0;
      g_valid_q    <= 1'b0;
      cell_x_q     <= '0;
      cell_y_out_q <= '0;
    end else begin
      px_col_q     <= px_col_d;
      cell_col_q   <= cell_col_d;
      cell_row_q   <= cell_row_d;
      cell_y_q     <= cell_y_d;
      h_acc_q      <= h_acc_d;
      g_q          <= g_d;
      g_valid_q    <= g_valid_d;
      cell_x_q     <= cell_x_d;
      cell_y_out_q <= cell_y_out_d;
    end
  end

  // Row 0 overwrites its entry, so stale contents never need a clear pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS_PER_LINE; i++) begin
        lbuf_q[i] <= '0;
      end
    end else if (lbuf_we) begin
      lbuf_q[cell_col_eff] <= row_sum;
    end
  end

  assign g       = g_q;
  assign g_valid = g_valid_q;
  assign cell_x  = cell_x_q;
  assign cell_y  = cell_y_out_q;

endmodule
`default_nettype wire
